// File: rtl/sap_out_if.sv
// Bus-side and consumer-side signals of the SAP multi-channel output port.
interface sap_out_if #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 2,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic [DATA_W-1:0]           bus;
  logic                        ld;
  logic [CH_W-1:0]             ch_sel;
  logic                        stall;
  logic [N_CH-1:0][DATA_W-1:0] out_data;
  logic [N_CH-1:0]             out_valid;
  logic [N_CH-1:0]             out_ack;
  logic [N_CH-1:0][DATA_W-1:0] disp;
  logic [N_CH-1:0]             full;
  logic [N_CH-1:0]             ovf;
  logic                        ovf_clr;

  // controller + consumers
  modport master (
    output bus, ld, ch_sel, out_ack, ovf_clr,
    input  stall, out_data, out_valid, disp, full, ovf
  );

  // the output port itself
  modport slave (
    input  bus, ld, ch_sel, out_ack, ovf_clr,
    output stall, out_data, out_valid, disp, full, ovf
  );
endinterface

// File: rtl/sap_out_port.sv
// SAP output port: N_CH independent FWFT FIFOs with display registers,
// sticky overflow flags and a combinational stall back to the controller.

// One output channel: FIFO, display register and overflow flag.
module sap_out_chan #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              sel,      // ld targets this channel
  input  logic              ack,
  input  logic              ovf_clr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] head,
  output logic [DATA_W-1:0] disp,
  output logic              valid,
  output logic              full,
  output logic              ovf,
  output logic              stall
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr, rptr;
  logic [CNT_W-1:0]  cnt;
  logic              push, pop;

  assign valid = (cnt != '0);
  assign full  = (cnt == CNT_W'(DEPTH));
  assign pop   = ack & valid;
  // a pop in the same cycle frees the slot the push will land in
  assign push  = sel & (~full | pop);
  assign stall = sel & full & ~ack;
  assign head  = valid ? mem[rptr] : '0;

  // storage write; contents are never reset
  always_ff @(posedge clk) begin
    if (clr && push) mem[wptr] <= wdata;
  end

  // pointers, occupancy, display register and sticky overflow
  always_ff @(posedge clk) begin
    if (!clr) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      disp <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
        disp <= mem[rptr];
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      // a fresh overflow beats a clear on the same edge
      if (stall)        ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end
endmodule

module sap_out_port #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int N_CH   = 2,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic     clk,
  input  logic     clr,
  sap_out_if.slave io
);
  logic [N_CH-1:0]             sel, ch_stall, ch_valid, ch_full, ch_ovf;
  logic [N_CH-1:0][DATA_W-1:0] ch_head, ch_disp;

  // out-of-range ch_sel matches no channel, so the load is silently ignored
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign sel[c] = io.ld & (io.ch_sel == CH_W'(c));

    sap_out_chan #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_chan (
      .clk     (clk),
      .clr     (clr),
      .sel     (sel[c]),
      .ack     (io.out_ack[c]),
      .ovf_clr (io.ovf_clr),
      .wdata   (io.bus),
      .head    (ch_head[c]),
      .disp    (ch_disp[c]),
      .valid   (ch_valid[c]),
      .full    (ch_full[c]),
      .ovf     (ch_ovf[c]),
      .stall   (ch_stall[c])
    );
  end

  assign io.stall     = |ch_stall;
  assign io.out_data  = ch_head;
  assign io.out_valid = ch_valid;
  assign io.full      = ch_full;
  assign io.ovf       = ch_ovf;
  assign io.disp      = ch_disp;
endmodule

// File: tb/tb_sap_out_port.sv
// Bench for sap_out_port (DATA_W=8, DEPTH=4, N_CH=3): table vectors,
// hand sequences and random traffic against a queue-based model.
module tb_sap_out_port;
  localparam int DW = 8, DEPTH = 4, NCH = 3;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  sap_out_if #(.DATA_W(DW), .N_CH(NCH)) io ();

  sap_out_port #(.DATA_W(DW), .DEPTH(DEPTH), .N_CH(NCH)) dut (
    .clk (clk),
    .clr (clr),
    .io  (io.slave)
  );

  // model: one queue per channel plus display and overflow state
  typedef logic [7:0] q_t [$];
  q_t         mq [NCH];
  logic [7:0] mdisp [NCH];
  logic [2:0] movf;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic m_stall(input logic l, input logic [1:0] s, input logic [2:0] a);
    if (!l || s >= 2'(NCH)) return 1'b0;
    return (mq[s].size() == DEPTH) && !a[s];
  endfunction

  task automatic m_edge(input logic c_clr, l, input logic [1:0] s, input logic [7:0] b,
                        input logic [2:0] a, input logic oc);
    logic pop [NCH];
    logic st;
    if (!c_clr) begin
      for (int c = 0; c < NCH; c++) begin mq[c].delete(); mdisp[c] = 8'h00; end
      movf = 3'b000;
      return;
    end
    st = m_stall(l, s, a);
    for (int c = 0; c < NCH; c++) pop[c] = a[c] && (mq[c].size() != 0);
    for (int c = 0; c < NCH; c++) begin
      if (pop[c]) mdisp[c] = mq[c].pop_front();
      if (l && s == 2'(c) && (mq[c].size() < DEPTH)) mq[c].push_back(b);
      if (st && s == 2'(c)) movf[c] = 1'b1;
      else if (oc)          movf[c] = 1'b0;
    end
  endtask

  task automatic check_state();
    logic [2:0]  ev, ef;
    logic [23:0] ed, ep;
    for (int c = 0; c < NCH; c++) begin
      ev[c] = mq[c].size() != 0;
      ef[c] = mq[c].size() == DEPTH;
      ed[c*8 +: 8] = (mq[c].size() != 0) ? mq[c][0] : 8'h00;
      ep[c*8 +: 8] = mdisp[c];
    end
    chk("out_valid", 32'(io.out_valid), 32'(ev));
    chk("full",      32'(io.full),      32'(ef));
    chk("out_data",  32'(io.out_data),  32'(ed));
    chk("disp",      32'(io.disp),      32'(ep));
    chk("ovf",       32'(io.ovf),       32'(movf));
  endtask

  // one clock: drive, check stall, edge, update model, check state
  task automatic cyc(input logic c_clr, l, input logic [1:0] s, input logic [7:0] b,
                     input logic [2:0] a, input logic oc, output logic st);
    clr = c_clr; io.ld = l; io.ch_sel = s; io.bus = b; io.out_ack = a; io.ovf_clr = oc;
    #2;
    st = io.stall;
    chk("stall", 32'(io.stall), 32'(m_stall(l, s, a)));
    @(posedge clk);
    m_edge(c_clr, l, s, b, a, oc);
    #1;
    check_state();
  endtask

  typedef struct {
    logic clr, ld; logic [1:0] sel; logic [7:0] bus; logic [2:0] ack; logic oc;
    logic e_st; logic [2:0] e_v, e_f, e_o; logic [7:0] e_h0;
  } vec_t;
  vec_t tv [13];

  logic st;
  logic [7:0] prev;

  initial begin
    //           clr  ld   sel  bus    ack     oc    st    valid   full    ovf     head0
    tv[0]  = '{1'b0,1'b1,2'd0,8'h55,3'b000,1'b0, 1'b0,3'b000,3'b000,3'b000,8'h00};
    tv[1]  = '{1'b1,1'b1,2'd0,8'h2A,3'b000,1'b0, 1'b0,3'b001,3'b000,3'b000,8'h2A};
    tv[2]  = '{1'b1,1'b0,2'd0,8'h00,3'b001,1'b0, 1'b0,3'b000,3'b000,3'b000,8'h00};
    tv[3]  = '{1'b1,1'b1,2'd0,8'h10,3'b000,1'b0, 1'b0,3'b001,3'b000,3'b000,8'h10};
    tv[4]  = '{1'b1,1'b1,2'd0,8'h11,3'b000,1'b0, 1'b0,3'b001,3'b000,3'b000,8'h10};
    tv[5]  = '{1'b1,1'b1,2'd0,8'h12,3'b000,1'b0, 1'b0,3'b001,3'b000,3'b000,8'h10};
    tv[6]  = '{1'b1,1'b1,2'd0,8'h13,3'b000,1'b0, 1'b0,3'b001,3'b001,3'b000,8'h10};
    tv[7]  = '{1'b1,1'b1,2'd0,8'h14,3'b000,1'b0, 1'b1,3'b001,3'b001,3'b001,8'h10};
    tv[8]  = '{1'b1,1'b1,2'd0,8'h14,3'b001,1'b0, 1'b0,3'b001,3'b001,3'b001,8'h11};
    tv[9]  = '{1'b1,1'b1,2'd0,8'h15,3'b000,1'b1, 1'b1,3'b001,3'b001,3'b001,8'h11};
    tv[10] = '{1'b1,1'b0,2'd0,8'h00,3'b000,1'b1, 1'b0,3'b001,3'b001,3'b000,8'h11};
    tv[11] = '{1'b1,1'b1,2'd3,8'hFF,3'b000,1'b0, 1'b0,3'b001,3'b001,3'b000,8'h11};
    tv[12] = '{1'b1,1'b1,2'd3,8'hFE,3'b000,1'b1, 1'b0,3'b001,3'b001,3'b000,8'h11};

    for (int c = 0; c < NCH; c++) mdisp[c] = 8'h00;
    movf = 3'b000;

    // first reset edge from unknown power-up state, not checked
    clr = 1'b0; io.ld = 1'b1; io.ch_sel = 2'd0; io.bus = 8'h55; io.out_ack = 3'b000; io.ovf_clr = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      cyc(tv[i].clr, tv[i].ld, tv[i].sel, tv[i].bus, tv[i].ack, tv[i].oc, st);
      chk($sformatf("tv%0d_stall", i), 32'(st),           32'(tv[i].e_st));
      chk($sformatf("tv%0d_valid", i), 32'(io.out_valid), 32'(tv[i].e_v));
      chk($sformatf("tv%0d_full", i),  32'(io.full),      32'(tv[i].e_f));
      chk($sformatf("tv%0d_ovf", i),   32'(io.ovf),       32'(tv[i].e_o));
      chk($sformatf("tv%0d_head0", i), 32'(io.out_data[0]), 32'(tv[i].e_h0));
    end

    // drain ch0: pop order 11,12,13,14 (10 was popped while 14 went in)
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 2'd0, 8'h00, 3'b001, 1'b0, st);
      chk("drain_disp0", 32'(io.disp[0]), 32'(8'h11 + i));
    end
    chk("drain_empty", 32'(io.out_valid[0]), 32'd0);

    // order and wrap on ch1: three pushes, then push+ack, then drain
    for (int i = 1; i <= 6; i++)
      cyc(1'b1, 1'b1, 2'd1, 8'(i), (i > 3) ? 3'b010 : 3'b000, 1'b0, st);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 2'd1, 8'h00, 3'b010, 1'b0, st);
    chk("wrap_last_disp", 32'(io.disp[1]), 32'h06);
    chk("wrap_empty",     32'(io.out_valid[1]), 32'd0);

    // empty ch0: push plus ack, ack must be ignored
    prev = mdisp[0];
    cyc(1'b1, 1'b1, 2'd0, 8'hAA, 3'b001, 1'b0, st);
    chk("emptyack_valid", 32'(io.out_valid[0]), 32'd1);
    chk("emptyack_disp",  32'(io.disp[0]),      32'(prev));
    // push ch0 while acking ch1
    cyc(1'b1, 1'b1, 2'd1, 8'h77, 3'b000, 1'b0, st);
    cyc(1'b1, 1'b1, 2'd0, 8'hBB, 3'b010, 1'b0, st);
    chk("cross_disp1", 32'(io.disp[1]), 32'h77);

    // mid-operation reset with queued words everywhere
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 2'(c), 8'($urandom), 3'b000, 1'b0, st);
    cyc(1'b0, 1'b1, 2'd2, 8'h99, 3'b111, 1'b1, st);
    chk("rst_valid", 32'(io.out_valid), 32'd0);
    chk("rst_disp",  32'(io.disp),      32'd0);
    cyc(1'b1, 1'b1, 2'd2, 8'h5C, 3'b000, 1'b0, st);
    chk("rst_push", 32'(io.out_data[2]), 32'h5C);

    // random traffic
    for (int i = 0; i < 1500; i++)
      cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
          8'($urandom), 3'($urandom) & 3'($urandom), ($urandom_range(0, 15) == 0), st);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
